ps2_rx_keyq: RTL

- Parametrised PS/2 keyboard receiver, successor to the single-code key reader.
- Oversamples and deglitches the PS/2 lines, then assembles 11-bit frames with full start/stop/odd-parity checking and a bit-gap timeout.
- Decodes E0 (extended) and F0 (break) prefixes into one event per key transition.
- Buffers events in a FIFO with a valid/ready handshake. Consumers are the text-entry and control logic, which no longer need to catch a held one-shot code.

---
 rtl/ps2_pkg.sv | 31 +++
 rtl/ps2_evt_fifo.sv | 62 ++++++
 rtl/ps2_rx_keyq.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver and its event FIFO.
// Scan-code prefixes, common key codes, event record and frame FSM states.
package ps2_pkg;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

    localparam logic [7:0] KEY_ENTER     = 8'h5A;
    localparam logic [7:0] KEY_SPACE     = 8'h29;
    localparam logic [7:0] KEY_BACKSPACE = 8'h66;
    localparam logic [7:0] KEY_LEFT      = 8'h6B;
    localparam logic [7:0] KEY_RIGHT     = 8'h74;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_evt_t;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        CHECK
    } ps2_state_t;

    // Frame is held LSB-first: [0] start, [8:1] data, [9] odd parity, [10] stop.
    function automatic logic frame_ok(input logic [10:0] frame);
        return !frame[0] && frame[10] && (^frame[9:1]);
    endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// First-word-fall-through FIFO of key events with occupancy, full and empty flags.
// The head entry reads as all-zero whenever the FIFO is empty.
module ps2_evt_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  ps2_evt_t               wr_evt,
    input  logic                   pop,
    output ps2_evt_t               rd_evt,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    ps2_evt_t      mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == FULL_CNT);
        do_pop   = pop && !empty;
        // A pop frees the slot a simultaneous push needs, so full only blocks a lone push.
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        rd_evt   = empty ? '0 : mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array has no reset; count and pointers alone decide which
    // entries are live, which keeps the array mappable onto plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_evt;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/ps2_rx_keyq.sv
// PS/2 keyboard receiver: synchronise, oversample and deglitch the lines, assemble
// and check 11-bit frames, fold E0/F0 prefixes into key events and queue them.
module ps2_rx_keyq
    import ps2_pkg::*;
#(
    parameter int CLK_DIV       = 250,
    parameter int TIMEOUT_TICKS = 4000,
    parameter int FILTER_LEN    = 4,
    parameter int FIFO_DEPTH    = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ps2_clk,
    input  logic                        ps2_data,
    output logic                        evt_valid,
    input  logic                        evt_ready,
    output logic [7:0]                  evt_code,
    output logic                        evt_break,
    output logic                        evt_ext,
    output logic                        frame_err,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int GAP_W = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(TIMEOUT_TICKS);

    logic [1:0]            clk_sync_q, clk_sync_d;
    logic [1:0]            dat_sync_q, dat_sync_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic [FILTER_LEN-1:0] hist_q, hist_d;
    logic                  filt_q, filt_d;
    ps2_state_t            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [10:0]           shift_q, shift_d;
    logic [GAP_W-1:0]      gap_q, gap_d;
    logic                  ext_q, ext_d;
    logic                  brk_q, brk_d;
    logic                  frame_err_q, frame_err_d;
    logic                  overflow_q, overflow_d;

    logic                  tick, fall;
    logic                  push, pop, fifo_full, fifo_empty;
    ps2_evt_t              push_evt, head_evt;

    // Front end: synchronisers, sample tick and clock deglitch filter.
    // NOTE: every combinational output gets a default before any branch, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        clk_sync_d = {clk_sync_q[0], ps2_clk};
        dat_sync_d = {dat_sync_q[0], ps2_data};
        tick       = (div_q == DIV_MAX);
        div_d      = tick ? '0 : div_q + DIV_W'(1);
        hist_d     = hist_q;
        filt_d     = filt_q;
        if (tick) begin
            hist_d = {hist_q[FILTER_LEN-2:0], clk_sync_q[1]};
            if (&hist_d) begin
                filt_d = 1'b1;
            end else if (hist_d == '0) begin
                filt_d = 1'b0;
            end
        end
        fall = tick && filt_q && !filt_d;
    end

    // Frame assembly, checking and prefix decoding.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        gap_d       = gap_q;
        ext_d       = ext_q;
        brk_d       = brk_q;
        frame_err_d = 1'b0;
        push        = 1'b0;
        push_evt    = '{ext: ext_q, brk: brk_q, code: shift_q[8:1]};
        unique case (state_q)
            IDLE: begin
                gap_d = '0;
                if (fall) begin
                    shift_d = {dat_sync_q[1], shift_q[10:1]};
                    cnt_d   = 4'd1;
                    state_d = RECV;
                end
            end
            RECV: begin
                if (gap_q == GAP_MAX) begin
                    frame_err_d = 1'b1;
                    ext_d       = 1'b0;
                    brk_d       = 1'b0;
                    cnt_d       = '0;
                    state_d     = IDLE;
                end else if (fall) begin
                    shift_d = {dat_sync_q[1], shift_q[10:1]};
                    cnt_d   = cnt_q + 4'd1;
                    gap_d   = '0;
                    if (cnt_q == 4'd10) begin
                        state_d = CHECK;
                    end
                end else if (tick) begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            CHECK: begin
                state_d = IDLE;
                cnt_d   = '0;
                if (!frame_ok(shift_q)) begin
                    frame_err_d = 1'b1;
                    ext_d       = 1'b0;
                    brk_d       = 1'b0;
                end else if (shift_q[8:1] == PS2_PREFIX_EXT) begin
                    ext_d = 1'b1;
                end else if (shift_q[8:1] == PS2_PREFIX_BRK) begin
                    brk_d = 1'b1;
                end else begin
                    push  = 1'b1;
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pop        = evt_valid && evt_ready;
        overflow_d = overflow_q || (push && fifo_full && !pop);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // its _d value from the same pre-edge snapshot, independent of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync_q  <= 2'b11;
            dat_sync_q  <= 2'b11;
            div_q       <= '0;
            hist_q      <= '1;
            filt_q      <= 1'b1;
            state_q     <= IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            gap_q       <= '0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            dat_sync_q  <= dat_sync_d;
            div_q       <= div_d;
            hist_q      <= hist_d;
            filt_q      <= filt_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            gap_q       <= gap_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
        end
    end

    ps2_evt_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (push),
        .wr_evt (push_evt),
        .pop    (pop),
        .rd_evt (head_evt),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    assign evt_valid = !fifo_empty;
    assign evt_code  = head_evt.code;
    assign evt_break = head_evt.brk;
    assign evt_ext   = head_evt.ext;
    assign frame_err = frame_err_q;
    assign overflow  = overflow_q;

endmodule
